// File: rtl/seg7_defs_pkg.sv
// Shared font constants and a clog2 helper for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low (0 = lit).
package seg7_defs;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_lut
  import seg7_defs::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-latched inputs and anti-ghost gap.
// Optional LEADING_ZERO_SUPPRESS_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver
  import seg7_defs::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 8,
  parameter int GAP        = 1,
  parameter int ANODE_LOW  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [4*NUM_DIGITS-1:0]        hex,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  input  logic [NUM_DIGITS-1:0]          blank,
  output logic [NUM_DIGITS-1:0]          anode,
  output logic [6:0]                     segment,
  output logic                           dp,
  output logic [clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                           frame_done
);

  localparam int IW = clog2(NUM_DIGITS);
  localparam int DW = clog2(SCAN_DIV);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_LOW != 0) ? '1 : '0;

  logic [DW-1:0]           div_cnt_reg;
  logic [IW-1:0]           digit_idx_reg;
  logic                    primed_reg;
  logic [4*NUM_DIGITS-1:0] shadow_hex_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [NUM_DIGITS-1:0]   shadow_blank_reg;
  logic [NUM_DIGITS-1:0]   anode_reg;
  logic [6:0]              segment_reg;
  logic                    dp_reg;
  logic                    frame_done_reg;

  logic                    first_en;
  logic                    slot_end;
  logic                    frame_end;
  logic [4*NUM_DIGITS-1:0] src_hex;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_blank;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   strobe;
  logic [NUM_DIGITS-1:0]   anode_on;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;
  logic                    cur_dark;
  logic                    in_gap;

  assign first_en  = en && !primed_reg;
  assign slot_end  = (div_cnt_reg == DW'(SCAN_DIV - 1));
  assign frame_end = en && slot_end && (digit_idx_reg == IW'(NUM_DIGITS - 1));

  // The very first enabled cycle decodes straight from the inputs, since the shadow
  // copy only lands on that same edge.
  assign src_hex   = first_en ? hex   : shadow_hex_reg;
  assign src_dp    = first_en ? dp_in : shadow_dp_reg;
  assign src_blank = first_en ? blank : shadow_blank_reg;

`ifdef LEADING_ZERO_SUPPRESS_EN
  // Walk down from the top digit; suppression stops at the first non-zero nibble or lit dp.
  always_comb begin
    logic run;
    suppress = '0;
    run      = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run         = run && (src_hex[4*i +: 4] == 4'h0) && !src_dp[i];
      suppress[i] = run;
    end
  end
`else
  assign suppress = '0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_strobe
      assign strobe[gi] = (digit_idx_reg == IW'(gi));
    end
  endgenerate

  assign anode_on   = (ANODE_LOW != 0) ? ~strobe : strobe;
  assign cur_nibble = src_hex[4*int'(digit_idx_reg) +: 4];
  assign cur_dark   = src_blank[digit_idx_reg] || suppress[digit_idx_reg];
  assign in_gap     = (int'(div_cnt_reg) < GAP);

  seg7_hex_lut u_lut (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg      <= '0;
      digit_idx_reg    <= '0;
      primed_reg       <= 1'b0;
      shadow_hex_reg   <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      anode_reg        <= ANODE_OFF;
      segment_reg      <= SEG_OFF;
      dp_reg           <= 1'b1;
      frame_done_reg   <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      if (en) begin
        div_cnt_reg <= slot_end ? '0 : div_cnt_reg + 1'b1;
        if (slot_end) begin
          digit_idx_reg <= (digit_idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx_reg + 1'b1;
        end
        if (first_en || frame_end) begin
          shadow_hex_reg   <= hex;
          shadow_dp_reg    <= dp_in;
          shadow_blank_reg <= blank;
        end
        primed_reg  <= 1'b1;
        anode_reg   <= in_gap ? ANODE_OFF : anode_on;
        segment_reg <= cur_dark ? SEG_OFF : cur_seg;
        dp_reg      <= cur_dark ? 1'b1 : ~src_dp[digit_idx_reg];
      end else begin
        anode_reg   <= ANODE_OFF;
        segment_reg <= SEG_OFF;
        dp_reg      <= 1'b1;
      end
    end
  end

  assign anode      = anode_reg;
  assign segment    = segment_reg;
  assign dp         = dp_reg;
  assign digit_idx  = digit_idx_reg;
  assign frame_done = frame_done_reg;

endmodule
